// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - op code and state enums shared by the multiply/divide unit
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIX
    } state_e;

    localparam logic [2:0] OP_LAST = 3'd5;

    function automatic logic is_signed_op(input op_e o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// rtl/muldiv_div_core.sv - restoring divider on unsigned magnitudes, one quotient bit per step
module muldiv_div_core
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    // The dividend shifts out of quo_q MSB-first while quotient bits fill in from the LSB.
    always_comb begin
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted[WIDTH-1:0] - dvs_q;
        if (start) begin
            quo_d = dividend;
            rem_d = '0;
            dvs_d = divisor;
        end else if (step) begin
            if (shifted >= {1'b0, dvs_q}) begin
                rem_d = diff;
                quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d = shifted[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            dvs_q <= dvs_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative HI/LO multiply/divide unit; MULDIV_FAST_MULT_EN selects a single-cycle multiply
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    op_e                op_q, op_d;
    logic [WIDTH-1:0]   mag_a_q, mag_a_d;
    logic               neg_a_q, neg_a_d;
    logic               neg_b_q, neg_b_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;

    logic               in_signed, in_neg_a, in_neg_b;
    logic [WIDTH-1:0]   in_mag_a, in_mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mag_prod, signed_prod;
    logic [WIDTH-1:0]   quotient, remainder, quo_s, rem_s;
    logic [WIDTH-1:0]   res_hi, res_lo;
    logic               div_start, div_step;

    muldiv_div_core #(.WIDTH(WIDTH)) u_div_core (
        .CLK       (CLK),
        .RESET     (RESET),
        .start     (div_start),
        .step      (div_step),
        .dividend  (in_mag_a),
        .divisor   (in_mag_b),
        .quotient  (quotient),
        .remainder (remainder)
    );

    // Operands are reduced to magnitudes at accept; only the sign bits travel to FIX.
    always_comb begin
        in_signed = is_signed_op(op_e'(op));
        in_neg_a  = in_signed & A[WIDTH-1];
        in_neg_b  = in_signed & B[WIDTH-1];
        in_mag_a  = in_neg_a ? -A : A;
        in_mag_b  = in_neg_b ? -B : B;
    end

    always_comb begin
        mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mag_a_q} : '0);
`ifdef MULDIV_FAST_MULT_EN
        mag_prod = {{WIDTH{1'b0}}, mag_a_q} * {{WIDTH{1'b0}}, prod_q[WIDTH-1:0]};
`else
        mag_prod = prod_q;
`endif
        signed_prod = (neg_a_q ^ neg_b_q) ? -mag_prod : mag_prod;
        quo_s       = (neg_a_q ^ neg_b_q) ? -quotient : quotient;
        rem_s       = neg_a_q ? -remainder : remainder;
        if (op_q == OP_MULT || op_q == OP_MULTU) begin
            res_hi = signed_prod[2*WIDTH-1:WIDTH];
            res_lo = signed_prod[WIDTH-1:0];
        end else begin
            res_hi = rem_s;
            res_lo = quo_s;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        mag_a_d   = mag_a_q;
        neg_a_d   = neg_a_q;
        neg_b_d   = neg_b_q;
        prod_d    = prod_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dz_d      = 1'b0;
        div_start = 1'b0;
        div_step  = 1'b0;
        if (cancel) begin
            state_d = IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && op <= OP_LAST) begin
                        op_d    = op_e'(op);
                        mag_a_d = in_mag_a;
                        neg_a_d = in_neg_a;
                        neg_b_d = in_neg_b;
                        cnt_d   = '0;
                        case (op_e'(op))
                            OP_MULT, OP_MULTU: begin
                                prod_d = {{WIDTH{1'b0}}, in_mag_b};
                                busy_d = 1'b1;
`ifdef MULDIV_FAST_MULT_EN
                                state_d = FIX;
`else
                                state_d = MUL;
`endif
                            end
                            OP_DIV, OP_DIVU: begin
                                if (B == '0) begin
                                    done_d = 1'b1;
                                    dz_d   = 1'b1;
                                end else begin
                                    div_start = 1'b1;
                                    busy_d    = 1'b1;
                                    state_d   = DIV;
                                end
                            end
                            OP_MTHI: begin
                                hi_d   = A;
                                done_d = 1'b1;
                            end
                            default: begin
                                lo_d   = A;
                                done_d = 1'b1;
                            end
                        endcase
                    end
                end
                MUL: begin
                    prod_d = {mul_sum, prod_q[WIDTH-1:1]};
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) state_d = FIX;
                end
                DIV: begin
                    div_step = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) state_d = FIX;
                end
                default: begin
                    hi_d    = res_hi;
                    lo_d    = res_lo;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= OP_MULT;
            mag_a_q <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            prod_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            mag_a_q <= mag_a_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            prod_q  <= prod_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;
    assign HI       = hi_q;
    assign LO       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized self-checking bench for muldiv_unit against an arithmetic model
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MULT_EN
    localparam int MULT_LAT = 1;
`else
    localparam int MULT_LAT = 33;
`endif

    logic        CLK = 1'b0;
    logic        RESET, start, cancel;
    logic [2:0]  op;
    logic [31:0] A, B;
    logic        busy, done, div_zero;
    logic [31:0] HI, LO;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    muldiv_unit #(.WIDTH(32)) dut (
        .CLK(CLK), .RESET(RESET), .start(start), .op(op), .A(A), .B(B),
        .cancel(cancel), .busy(busy), .done(done), .div_zero(div_zero),
        .HI(HI), .LO(LO)
    );

    always #5 CLK = ~CLK;

    function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  inout logic [31:0] hi, inout logic [31:0] lo);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd0: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
            3'd1: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
            3'd2: if (b != 0) begin
                q = sa / sb; r = sa % sb; p = q; lo = p[31:0]; p = r; hi = p[31:0];
            end
            3'd3: if (b != 0) begin lo = a / b; hi = a % b; end
            3'd4: hi = a;
            3'd5: lo = a;
            default: ;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] o, input logic [31:0] b);
        if (o == 3'd0 || o == 3'd1) return MULT_LAT;
        if ((o == 3'd2 || o == 3'd3) && b != 0) return 33;
        return 0;
    endfunction

    // Starts one operation, scrambles the inputs after accept, and measures edges until done.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic busy0, output logic busy_done,
                         output logic dz_seen, output logic done_after);
        start = 1'b1; op = o; A = a; B = b;
        @(posedge CLK); #1;
        start = 1'b0; op = 3'($urandom_range(0, 5)); A = $urandom; B = $urandom;
        busy0 = busy;
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge CLK); #1;
            lat++;
        end
        dz_seen = div_zero;
        busy_done = busy;
        @(posedge CLK); #1;
        done_after = done;
    endtask

    task automatic test_reset();
        int lat; logic b0, bd, dz, da;
        RESET = 1'b1; start = 1'b0; cancel = 1'b0; op = 3'd0; A = '0; B = '0;
        repeat (2) @(posedge CLK);
        #1;
        n_tests++; if ({HI, LO} !== 64'd0) begin n_fail++; $display("FAIL reset_hilo got %h exp 0", {HI, LO}); end
        n_tests++; if ({busy, done, div_zero} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b exp 000", {busy, done, div_zero}); end
        RESET = 1'b0;
        issue(3'd4, 32'h0000_abcd, 32'd0, lat, b0, bd, dz, da);
        exp_hi = 32'h0000_abcd;
        n_tests++; if (lat !== 0 || HI !== exp_hi) begin n_fail++; $display("FAIL first_accept got lat %0d hi %h exp 0 %h", lat, HI, exp_hi); end
    endtask

    task automatic test_mult();
        int lat; logic b0, bd, dz, da;
        logic [2:0] o; logic [31:0] a, b;
        issue(3'd0, -32'sd3, 32'd7, lat, b0, bd, dz, da);
        model(3'd0, -32'sd3, 32'd7, exp_hi, exp_lo);
        n_tests++; if ({HI, LO} !== 64'hFFFF_FFFF_FFFF_FFEB) begin n_fail++; $display("FAIL mult_neg3x7 got %h exp ffffffffffffffeb", {HI, LO}); end
        n_tests++; if (lat !== MULT_LAT) begin n_fail++; $display("FAIL mult_latency got %0d exp %0d", lat, MULT_LAT); end
        n_tests++; if (b0 !== 1'b1 || bd !== 1'b0 || da !== 1'b0) begin n_fail++; $display("FAIL mult_busy_done got %b%b%b exp 100", b0, bd, da); end
        for (int i = 0; i < 6; i++) begin
            o = 3'(i % 2); a = $urandom; b = $urandom;
            issue(o, a, b, lat, b0, bd, dz, da);
            model(o, a, b, exp_hi, exp_lo);
            n_tests++; if ({HI, LO} !== {exp_hi, exp_lo} || lat !== MULT_LAT) begin
                n_fail++; $display("FAIL mult_rand op %0d a %h b %h got %h lat %0d exp %h lat %0d", o, a, b, {HI, LO}, lat, {exp_hi, exp_lo}, MULT_LAT);
            end
        end
    endtask

    task automatic test_div();
        int lat; logic b0, bd, dz, da;
        logic [2:0] o; logic [31:0] a, b;
        issue(3'd2, -32'sd7, 32'd2, lat, b0, bd, dz, da);
        n_tests++; if ({HI, LO} !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_fail++; $display("FAIL div_neg7_2 got %h exp ffffffff_fffffffd", {HI, LO}); end
        n_tests++; if (lat !== 33 || dz !== 1'b0 || b0 !== 1'b1 || da !== 1'b0) begin n_fail++; $display("FAIL div_timing got lat %0d dz %b busy %b exp 33 0 1", lat, dz, b0); end
        issue(3'd3, 32'd7, 32'd2, lat, b0, bd, dz, da);
        n_tests++; if ({HI, LO} !== {32'd1, 32'd3}) begin n_fail++; $display("FAIL divu_7_2 got %h exp 1_3", {HI, LO}); end
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, lat, b0, bd, dz, da);
        n_tests++; if ({HI, LO} !== {32'd0, 32'h8000_0000} || dz !== 1'b0) begin n_fail++; $display("FAIL div_minneg got %h dz %b exp 0_80000000 0", {HI, LO}, dz); end
        model(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, exp_hi, exp_lo);
        for (int i = 0; i < 8; i++) begin
            o = 3'(2 + i % 2); a = $urandom;
            b = (i < 4) ? 32'($urandom_range(1, 300)) - ((i % 2 == 0) ? 32'd150 : 32'd0) : $urandom;
            if (b == 0) b = 32'd5;
            issue(o, a, b, lat, b0, bd, dz, da);
            model(o, a, b, exp_hi, exp_lo);
            n_tests++; if ({HI, LO} !== {exp_hi, exp_lo} || lat !== 33) begin
                n_fail++; $display("FAIL div_rand op %0d a %h b %h got %h lat %0d exp %h lat 33", o, a, b, {HI, LO}, lat, {exp_hi, exp_lo});
            end
        end
    endtask

    task automatic test_div_zero();
        int lat; logic b0, bd, dz, da;
        for (int i = 0; i < 2; i++) begin
            issue(3'(3 - i), $urandom, 32'd0, lat, b0, bd, dz, da);
            n_tests++; if (lat !== 0 || dz !== 1'b1 || b0 !== 1'b0 || da !== 1'b0) begin
                n_fail++; $display("FAIL div_zero_flags got lat %0d dz %b busy %b after %b exp 0 1 0 0", lat, dz, b0, da);
            end
            n_tests++; if ({HI, LO} !== {exp_hi, exp_lo}) begin n_fail++; $display("FAIL div_zero_hilo got %h exp %h", {HI, LO}, {exp_hi, exp_lo}); end
        end
    endtask

    task automatic test_cancel();
        int lat, ndone; logic b0, bd, dz, da;
        start = 1'b1; op = 3'd2; A = 32'd1000; B = 32'd7;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (9) @(posedge CLK);
        #1; cancel = 1'b1;
        @(posedge CLK); #1; cancel = 1'b0;
        n_tests++; if (busy !== 1'b0 || done !== 1'b0 || {HI, LO} !== {exp_hi, exp_lo}) begin
            n_fail++; $display("FAIL cancel_div got busy %b done %b hilo %h exp 0 0 %h", busy, done, {HI, LO}, {exp_hi, exp_lo});
        end
        issue(3'd1, 32'd12345, 32'd678, lat, b0, bd, dz, da);
        model(3'd1, 32'd12345, 32'd678, exp_hi, exp_lo);
        n_tests++; if (lat !== MULT_LAT || {HI, LO} !== {exp_hi, exp_lo}) begin
            n_fail++; $display("FAIL cancel_restart got lat %0d hilo %h exp %0d %h", lat, {HI, LO}, MULT_LAT, {exp_hi, exp_lo});
        end
        start = 1'b1; op = 3'd0; A = $urandom; B = $urandom;
        @(posedge CLK); #1; start = 1'b0;
        repeat (3) @(posedge CLK);
        #1; cancel = 1'b1;
        @(posedge CLK); #1; cancel = 1'b0;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin @(posedge CLK); #1; if (done) ndone++; end
        n_tests++; if (ndone !== 0 || busy !== 1'b0 || {HI, LO} !== {exp_hi, exp_lo}) begin
            n_fail++; $display("FAIL cancel_mul got dones %0d busy %b hilo %h exp 0 0 %h", ndone, busy, {HI, LO}, {exp_hi, exp_lo});
        end
        start = 1'b1; cancel = 1'b1; op = 3'd4; A = 32'hDEAD_BEEF;
        @(posedge CLK); #1; start = 1'b0; cancel = 1'b0;
        @(posedge CLK); #1;
        n_tests++; if (HI !== exp_hi || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL cancel_start got hi %h busy %b done %b exp %h 0 0", HI, busy, done, exp_hi);
        end
        start = 1'b1; op = 3'd6; A = 32'h1111_2222; B = 32'd3;
        @(posedge CLK); #1; start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 5; i++) begin if (done || busy) ndone++; @(posedge CLK); #1; end
        n_tests++; if (ndone !== 0 || {HI, LO} !== {exp_hi, exp_lo}) begin
            n_fail++; $display("FAIL illegal_op got activity %0d hilo %h exp 0 %h", ndone, {HI, LO}, {exp_hi, exp_lo});
        end
    endtask

    task automatic test_reset_mid_and_mt();
        int lat; logic b0, bd, dz, da;
        start = 1'b1; op = 3'd0; A = 32'd99; B = 32'd77;
        @(posedge CLK); #1; start = 1'b0;
        repeat (5) @(posedge CLK);
        #2; RESET = 1'b1; #1;
        n_tests++; if ({HI, LO} !== 64'd0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid got hilo %h busy %b done %b exp 0 0 0", {HI, LO}, busy, done);
        end
        exp_hi = 32'd0; exp_lo = 32'd0;
        @(negedge CLK); RESET = 1'b0;
        @(posedge CLK); #1;
        issue(3'd4, 32'h1234, 32'd0, lat, b0, bd, dz, da);
        n_tests++; if (HI !== 32'h1234 || LO !== 32'd0 || lat !== 0 || b0 !== 1'b0 || da !== 1'b0) begin
            n_fail++; $display("FAIL mthi got hi %h lo %h lat %0d busy %b exp 1234 0 0 0", HI, LO, lat, b0);
        end
        issue(3'd5, 32'h5678, 32'd0, lat, b0, bd, dz, da);
        n_tests++; if (HI !== 32'h1234 || LO !== 32'h5678 || lat !== 0 || da !== 1'b0) begin
            n_fail++; $display("FAIL mtlo got hi %h lo %h lat %0d exp 1234 5678 0", HI, LO, lat);
        end
        exp_hi = 32'h1234; exp_lo = 32'h5678;
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [31:0] a2, b2;
        start = 1'b1; op = 3'd1; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
        @(posedge CLK); #1; start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin @(posedge CLK); #1; lat++; end
        n_tests++; if ({HI, LO} !== 64'hFFFF_FFFE_0000_0001 || lat !== MULT_LAT) begin
            n_fail++; $display("FAIL b2b_first got %h lat %0d exp fffffffe00000001 %0d", {HI, LO}, lat, MULT_LAT);
        end
        a2 = $urandom; b2 = $urandom;
        start = 1'b1; op = 3'd0; A = a2; B = b2;
        @(posedge CLK); #1; start = 1'b0;
        model(3'd0, a2, b2, exp_hi, exp_lo);
        lat = 0;
        while (!done && lat < 100) begin @(posedge CLK); #1; lat++; end
        n_tests++; if ({HI, LO} !== {exp_hi, exp_lo} || lat !== MULT_LAT) begin
            n_fail++; $display("FAIL b2b_second got %h lat %0d exp %h %0d", {HI, LO}, lat, {exp_hi, exp_lo}, MULT_LAT);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_random();
        int lat; logic b0, bd, dz, da;
        logic [2:0] o; logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            o = 3'($urandom_range(0, 5)); a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            issue(o, a, b, lat, b0, bd, dz, da);
            model(o, a, b, exp_hi, exp_lo);
            n_tests++; if ({HI, LO} !== {exp_hi, exp_lo} || lat !== model_lat(o, b) || b0 !== (model_lat(o, b) > 0)
                           || dz !== ((o == 3'd2 || o == 3'd3) && b == 0) || bd !== 1'b0 || da !== 1'b0) begin
                n_fail++; $display("FAIL rand op %0d a %h b %h got %h lat %0d busy %b dz %b exp %h lat %0d",
                                   o, a, b, {HI, LO}, lat, b0, dz, {exp_hi, exp_lo}, model_lat(o, b));
            end
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_cancel();
        test_reset_mid_and_mt();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
